// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one external combinational ALU between N_REQ requesters.
// Optional feature: define ALU_OP_CHECK_EN to answer opcodes 3'b101..3'b111 with rsp_err instead of executing them.
module alu_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4,
    parameter int ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ*3-1:0]     req_op,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output logic [2:0]             alu_op,
    input  logic [WIDTH-1:0]       alu_result,
    input  logic                   alu_zero,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [WIDTH-1:0]       rsp_result,
    output logic                   rsp_zero,
    output logic                   rsp_err,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   winner;
    logic              found;
    logic [WIDTH-1:0]  sel_a;
    logic [WIDTH-1:0]  sel_b;
    logic [2:0]        sel_op;

    // Two passes: indices above last_grant first, then the wrapped-around ones.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && req_valid[i] && (i > 32'(last_grant))) begin
                found  = 1'b1;
                winner = ID_W'(i);
            end
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && req_valid[i] && (i <= 32'(last_grant))) begin
                found  = 1'b1;
                winner = ID_W'(i);
            end
        end
    end

    always_comb begin
        sel_a  = req_a[32'(winner)*WIDTH +: WIDTH];
        sel_b  = req_b[32'(winner)*WIDTH +: WIDTH];
        sel_op = req_op[32'(winner)*3 +: 3];
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && found) begin
            req_ready[winner] = 1'b1;
        end
    end

`ifdef ALU_OP_CHECK_EN
    logic illegal;
    assign illegal = (sel_op > 3'd4);
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= ID_W'(N_REQ - 1);
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            busy       <= 1'b0;
`ifdef ALU_OP_CHECK_EN
            rsp_err    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        last_grant <= winner;
                        busy       <= 1'b1;
`ifdef ALU_OP_CHECK_EN
                        // Illegal ops bypass the ALU and leave alu_* untouched.
                        if (illegal) begin
                            rsp_valid  <= 1'b1;
                            rsp_id     <= winner;
                            rsp_result <= '0;
                            rsp_zero   <= 1'b0;
                            rsp_err    <= 1'b1;
                            state      <= RESP;
                        end else
`endif
                        begin
                            alu_a  <= sel_a;
                            alu_b  <= sel_b;
                            alu_op <= sel_op;
                            state  <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    rsp_id     <= last_grant;
                    rsp_valid  <= 1'b1;
`ifdef ALU_OP_CHECK_EN
                    rsp_err    <= 1'b0;
`endif
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
